// File: rtl/icache_if.sv
// Instruction-fetch bundle: datapath request/response plus memory port.
// slave = cache side, master = datapath/memory environment side.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport slave (
    input  imemREN,
    input  imemaddr,
    output ihit,
    output imemload,
    output iREN,
    output iaddr,
    input  iwait,
    input  iload
  );

  modport master (
    output imemREN,
    output imemaddr,
    input  ihit,
    input  imemload,
    input  iREN,
    input  iaddr,
    output iwait,
    output iload
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one-word blocks.
// Hits answer combinationally; misses fetch one word then refetch hits.
module icache #(
  parameter int unsigned SETS  = 16,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  icache_if.slave     bus,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t state;
  state_t next;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [31:0]      data [SETS];
  logic [31:0]      miss_addr;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  logic             hit;
  logic             lookup;
  logic             miss_start;
  logic             fill;
  logic             unused;

  assign idx  = bus.imemaddr[IDX_W+1:2];
  assign tag  = bus.imemaddr[31:IDX_W+2];
  assign fidx = miss_addr[IDX_W+1:2];
  assign ftag = miss_addr[31:IDX_W+2];

  assign unused = ^{bus.imemaddr[1:0], miss_addr[1:0]};

  assign hit        = valid[idx] && (tags[idx] == tag);
  assign lookup     = (state == IDLE) && bus.imemREN;
  assign miss_start = lookup && !hit;
  assign fill       = (state == FETCH) && !bus.iwait;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:  if (miss_start) next = FETCH;
      FETCH: if (!bus.iwait) next = IDLE;
    endcase
  end

  always_comb begin
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    unique case (state)
      IDLE: begin
        bus.ihit = lookup && hit;
        if (bus.ihit) bus.imemload = data[idx];
      end
      FETCH: begin
        bus.iREN  = 1'b1;
        bus.iaddr = miss_addr;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid      <= '0;
      miss_addr  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (miss_start) begin
        miss_addr  <= bus.imemaddr;
        miss_count <= miss_count + 32'd1;
      end
      if (lookup && hit) hit_count <= hit_count + 32'd1;
      if (fill) valid[fidx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only read behind a valid bit.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tags[fidx] <= ftag;
      data[fidx] <= bus.iload;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Random and directed checks of icache against a set-indexed lookup model.
// Memory contents come from a fixed function of the address.
module tb_icache;
  logic        CLK;
  logic        nRST;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  icache_if bus();

  icache dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  bit          mv [16];
  logic [31:0] mt [16];
  logic [31:0] md [16];
  bit          pend;
  logic [31:0] paddr;
  logic [31:0] mhits;
  logic [31:0] mmiss;

  bit          c_ren;
  logic [31:0] c_addr;
  bit          c_wt;

  function automatic logic [31:0] memword(logic [31:0] a);
    if (a == 32'h0)  return 32'h3C010001;
    if (a == 32'h40) return 32'h20020005;
    return a * 32'h9E3779B1 + 32'h1357;
  endfunction

  function automatic int set_of(logic [31:0] a);
    return int'((a / 4) % 16);
  endfunction

  function automatic bit mhit(logic [31:0] a);
    return mv[set_of(a)] && mt[set_of(a)] == a / 64;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (mv[i]) mv[i] = 1'b0;
    pend  = 1'b0;
    paddr = '0;
    mhits = '0;
    mmiss = '0;
  endtask

  task automatic step(bit ren, logic [31:0] a, bit wt);
    logic        e_hit;
    @(negedge CLK);
    c_ren = ren;
    c_addr = a;
    c_wt = wt;
    bus.imemREN  = ren;
    bus.imemaddr = a;
    bus.iwait    = wt;
    bus.iload    = wt ? $urandom : memword(paddr);
    #1;
    e_hit = !pend && ren && mhit(a);
    chk("ihit", {31'b0, bus.ihit}, {31'b0, e_hit});
    chk("imemload", bus.imemload, e_hit ? md[set_of(a)] : 32'h0);
    chk("iREN", {31'b0, bus.iREN}, {31'b0, pend});
    chk("iaddr", bus.iaddr, pend ? paddr : 32'h0);
    chk("hit_count", hit_count, mhits);
    chk("miss_count", miss_count, mmiss);
  endtask

  task automatic adv();
    if (!pend) begin
      if (c_ren && mhit(c_addr)) mhits++;
      else if (c_ren) begin
        pend  = 1'b1;
        paddr = c_addr;
        mmiss++;
      end
    end else if (!c_wt) begin
      mv[set_of(paddr)] = 1'b1;
      mt[set_of(paddr)] = paddr / 64;
      md[set_of(paddr)] = memword(paddr);
      pend = 1'b0;
    end
    @(posedge CLK);
  endtask

  task automatic cyc(bit ren, logic [31:0] a, bit wt);
    step(ren, a, wt);
    adv();
  endtask

  task automatic rst_mid();
    #2 nRST = 1'b0;
    #1;
    chk("rst_iREN", {31'b0, bus.iREN}, 32'h0);
    chk("rst_ihit", {31'b0, bus.ihit}, 32'h0);
    chk("rst_iaddr", bus.iaddr, 32'h0);
    model_clear();
    bus.imemREN = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST = 1'b0;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    model_clear();
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_ihit", {31'b0, bus.ihit}, 32'h0);
    chk("reset_iREN", {31'b0, bus.iREN}, 32'h0);
    chk("reset_counts", hit_count | miss_count, 32'h0);
    nRST = 1'b1;

    step(1'b1, 32'h0, 1'b1);
    chk("t1_first_iREN", {31'b0, bus.iREN}, 32'h0);
    adv();
    step(1'b1, 32'h0, 1'b1);
    chk("t1_iREN", {31'b0, bus.iREN}, 32'h1);
    chk("t1_iaddr", bus.iaddr, 32'h0);
    adv();
    cyc(1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h0, 1'b1);
    cyc(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    chk("t1_ihit", {31'b0, bus.ihit}, 32'h1);
    chk("t1_load", bus.imemload, 32'h3C010001);
    chk("t1_miss_count", miss_count, 32'd1);
    adv();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h0, 1'b0);
    step(1'b1, 32'h40, 1'b1);
    chk("t2_hit_count", hit_count, 32'd4);
    adv();
    cyc(1'b1, 32'h40, 1'b0);
    step(1'b1, 32'h40, 1'b0);
    chk("t3_load40", bus.imemload, 32'h20020005);
    adv();
    cyc(1'b1, 32'h0, 1'b1);
    step(1'b1, 32'h0, 1'b1);
    chk("t3_iaddr", bus.iaddr, 32'h0);
    chk("t3_miss_count", miss_count, 32'd3);
    adv();
    cyc(1'b1, 32'h0, 1'b0);

    cyc(1'b1, 32'h8, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    chk("t4_iaddr_held", bus.iaddr, 32'h8);
    adv();
    cyc(1'b1, 32'h100, 1'b0);
    cyc(1'b1, 32'h100, 1'b1);
    step(1'b1, 32'h100, 1'b1);
    chk("t4_iaddr_new", bus.iaddr, 32'h100);
    adv();
    cyc(1'b1, 32'h100, 1'b0);
    step(1'b1, 32'h8, 1'b0);
    chk("t4_hit8", {31'b0, bus.ihit}, 32'h1);
    adv();

    for (int i = 0; i < 4; i++) begin
      step(1'b0, $urandom, 1'b0);
      chk("t5_ihit", {31'b0, bus.ihit}, 32'h0);
      adv();
    end

    cyc(1'b1, 32'h200, 1'b1);
    rst_mid();
    step(1'b1, 32'h0, 1'b1);
    chk("t6_ihit", {31'b0, bus.ihit}, 32'h0);
    chk("t6_counts", hit_count | miss_count, 32'h0);
    adv();

    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) < 8,
          32'($urandom_range(0, 47)) * 32'd4,
          $urandom_range(0, 1) == 0);
      if ($urandom_range(0, 599) == 0) rst_mid();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
